scedma_arb: RTL and testbench

Round-robin arbiter that shares one segment-memory port between `CHNLCNT` DMA channel requesters in the SCE DMA datapath, sitting downstream of per-channel access control and upstream of the segment RAM. Single-beat read/write requests are granted one per cycle. The ID of each accepted read is queued so that returning read data is routed back to the channel that issued it.

---
 rtl/scedma_arb.sv | 119 +++++++++++
 tb/tb_scedma_arb.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scedma_arb.sv
// Round-robin arbiter sharing one segment-memory port between DMA channels.
// Accepted read IDs are queued so returning data is steered back to its issuer.
module scedma_arb #(
    parameter int CHNLCNT = 4,
    parameter int AW      = 16,
    parameter int DW      = 32,
    parameter int RDQD    = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [CHNLCNT-1:0]      chnl_rd,
    input  logic [CHNLCNT-1:0]      chnl_wr,
    input  logic [CHNLCNT*AW-1:0]   chnl_addr,
    input  logic [CHNLCNT*DW-1:0]   chnl_wdat,
    output logic [CHNLCNT-1:0]      chnl_ready,
    output logic [DW-1:0]           chnl_rdat,
    output logic [CHNLCNT-1:0]      chnl_rdatvld,
    output logic                    mem_rd,
    output logic                    mem_wr,
    output logic [AW-1:0]           mem_addr,
    output logic [DW-1:0]           mem_wdat,
    input  logic                    mem_ready,
    input  logic [DW-1:0]           mem_rdat,
    input  logic                    mem_rdatvld,
    output logic [$clog2(RDQD):0]   rd_outstanding,
    output logic                    proterr
);

    localparam int PW = $clog2(CHNLCNT);
    localparam int QW = $clog2(RDQD);
    localparam int CW = QW + 1;

    logic [AW-1:0]      addr_a [CHNLCNT];
    logic [DW-1:0]      wdat_a [CHNLCNT];
    logic [PW-1:0]      idq    [RDQD];
    logic [PW-1:0]      rr_ptr;
    logic [PW-1:0]      gnt;
    logic [PW-1:0]      idx;
    logic               gnt_vld;
    logic [CHNLCNT-1:0] elig;
    logic [QW-1:0]      wptr;
    logic [QW-1:0]      rptr;
    logic [CW-1:0]      count;
    logic               rd_ok;
    logic               xfer;
    logic               both;
    logic               push;
    logic               pop;
    logic               spur;

    for (genvar i = 0; i < CHNLCNT; i++) begin : g_split
        assign addr_a[i] = chnl_addr[i*AW +: AW];
        assign wdat_a[i] = chnl_wdat[i*DW +: DW];
    end

    // A full FIFO blocks reads even if a pop lands this cycle: no rdatvld->ready path.
    assign rd_ok = count < CW'(RDQD);
    assign elig  = enable ? (chnl_wr | (chnl_rd & {CHNLCNT{rd_ok}})) : '0;

    // Walk downward so the last hit is the first eligible channel at/after rr_ptr.
    always_comb begin
        gnt     = '0;
        gnt_vld = 1'b0;
        idx     = '0;
        for (int k = CHNLCNT - 1; k >= 0; k--) begin
            idx = PW'((int'(rr_ptr) + k) % CHNLCNT);
            if (elig[idx]) begin
                gnt     = idx;
                gnt_vld = 1'b1;
            end
        end
    end

    assign both     = chnl_rd[gnt] & chnl_wr[gnt];
    assign mem_wr   = gnt_vld & chnl_wr[gnt];
    assign mem_rd   = gnt_vld & chnl_rd[gnt] & ~chnl_wr[gnt];
    assign mem_addr = gnt_vld ? addr_a[gnt] : '0;
    assign mem_wdat = gnt_vld ? wdat_a[gnt] : '0;
    assign xfer     = gnt_vld & mem_ready;
    assign push     = xfer & mem_rd;
    assign pop      = mem_rdatvld & (count != '0);
    assign spur     = mem_rdatvld & (count == '0);

    assign rd_outstanding = count;

    always_comb begin
        chnl_ready = '0;
        if (xfer) chnl_ready[gnt] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push) idq[wptr] <= gnt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr       <= '0;
            wptr         <= '0;
            rptr         <= '0;
            count        <= '0;
            chnl_rdatvld <= '0;
            chnl_rdat    <= '0;
            proterr      <= 1'b0;
        end else begin
            if (xfer) rr_ptr <= (gnt == PW'(CHNLCNT - 1)) ? '0 : gnt + 1'b1;
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            count        <= count + CW'(push) - CW'(pop);
            chnl_rdatvld <= '0;
            if (pop) begin
                chnl_rdatvld[idq[rptr]] <= 1'b1;
                chnl_rdat               <= mem_rdat;
            end
            proterr <= (xfer & both) | spur;
        end
    end

endmodule

// File: tb/tb_scedma_arb.sv
// Bench for scedma_arb: directed stimulus with a read-return scoreboard.
module tb_scedma_arb;
    localparam int N    = 4;
    localparam int AW   = 16;
    localparam int DW   = 32;
    localparam int RDQD = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            enable = 1'b1;
    logic [N-1:0]    chnl_rd = '0;
    logic [N-1:0]    chnl_wr = '0;
    logic [N*AW-1:0] chnl_addr = '0;
    logic [N*DW-1:0] chnl_wdat = '0;
    logic [N-1:0]    chnl_ready;
    logic [DW-1:0]   chnl_rdat;
    logic [N-1:0]    chnl_rdatvld;
    logic            mem_rd, mem_wr;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdat;
    logic            mem_ready = 1'b0;
    logic [DW-1:0]   mem_rdat = '0;
    logic            mem_rdatvld = 1'b0;
    logic [$clog2(RDQD):0] rd_outstanding;
    logic            proterr;

    always #5 clk = ~clk;

    scedma_arb #(.CHNLCNT(N), .AW(AW), .DW(DW), .RDQD(RDQD)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .chnl_rd(chnl_rd), .chnl_wr(chnl_wr), .chnl_addr(chnl_addr), .chnl_wdat(chnl_wdat),
        .chnl_ready(chnl_ready), .chnl_rdat(chnl_rdat), .chnl_rdatvld(chnl_rdatvld),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdat(mem_wdat),
        .mem_ready(mem_ready), .mem_rdat(mem_rdat), .mem_rdatvld(mem_rdatvld),
        .rd_outstanding(rd_outstanding), .proterr(proterr)
    );

    typedef struct {
        int            id;
        logic [DW-1:0] data;
        int            due;
    } rexp_t;

    rexp_t sbq[$];
    int    idq[$];
    int    cyc = 0;
    int    n_chk = 0;
    int    n_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic set_req(input int ch, input logic rd, input logic wr,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        chnl_rd[ch] = rd;
        chnl_wr[ch] = wr;
        chnl_addr[ch*AW +: AW] = a;
        chnl_wdat[ch*DW +: DW] = d;
    endtask

    task automatic clr_req();
        chnl_rd = '0;
        chnl_wr = '0;
    endtask

    // Single read from one channel, accepted in the same cycle.
    task automatic rd_one(input int ch, input logic [AW-1:0] a, input string tag);
        clr_req();
        set_req(ch, 1'b1, 1'b0, a, '0);
        mem_ready = 1'b1;
        mid();
        chk(tag, chnl_ready, 64'(1) << ch);
        chk({tag, "_addr"}, mem_addr, a);
        idq.push_back(ch);
        tick();
        clr_req();
        mem_ready = 1'b0;
    endtask

    // Drive one memory return; legitimate ones get an expected routing entry.
    task automatic ret(input logic [DW-1:0] d);
        rexp_t e;
        mem_rdatvld = 1'b1;
        mem_rdat    = d;
        if (idq.size() > 0) begin
            e.id   = idq.pop_front();
            e.data = d;
            e.due  = cyc + 1;
            sbq.push_back(e);
        end
    endtask

    initial begin
        forever begin
            rexp_t e;
            @(negedge clk);
            if (chnl_rdatvld !== '0) begin
                if (sbq.size() == 0) begin
                    chk("unexp_rdatvld", chnl_rdatvld, 0);
                end else begin
                    e = sbq.pop_front();
                    chk("rdatvld_id", chnl_rdatvld, 64'(1) << e.id);
                    chk("rdat", chnl_rdat, e.data);
                    chk("rdat_lat", cyc, e.due);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int gq[$];
        int g;

        repeat (3) tick();
        reset = 1'b0;
        mid();
        chk("rst_cnt", rd_outstanding, 0);
        chk("rst_rdatvld", chnl_rdatvld, 0);
        chk("rst_rdat", chnl_rdat, 0);
        chk("rst_perr", proterr, 0);
        chk("rst_memrd", mem_rd, 0);
        chk("rst_memwr", mem_wr, 0);
        chk("rst_ready", chnl_ready, 0);
        tick();

        // rotation: all channels write continuously
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 1'b1, AW'(16'h100 + i), DW'(32'hC0DE0000 + i));
        mem_ready = 1'b1;
        gq = '{0, 1, 2, 3, 0};
        while (gq.size() > 0) begin
            g = gq.pop_front();
            mid();
            chk("rot_ready", chnl_ready, 64'(1) << g);
            chk("rot_addr", mem_addr, 16'h100 + g);
            chk("rot_wdat", mem_wdat, 32'hC0DE0000 + g);
            chk("rot_memwr", mem_wr, 1);
            tick();
        end
        clr_req();
        mem_ready = 1'b0;

        // backpressure on a ch2 read (rr_ptr is 1 here)
        set_req(2, 1'b1, 1'b0, 16'h0010, '0);
        repeat (3) begin
            mid();
            chk("bp_ready", chnl_ready, 0);
            chk("bp_memrd", mem_rd, 1);
            chk("bp_addr", mem_addr, 16'h0010);
            tick();
        end
        mem_ready = 1'b1;
        mid();
        chk("bp_accept", chnl_ready, 4);
        idq.push_back(2);
        tick();
        clr_req();
        // ch0 and ch3 both write: ch3 wins only if rr_ptr advanced to 3
        set_req(0, 1'b0, 1'b1, 16'h0200, 32'h1);
        set_req(3, 1'b0, 1'b1, 16'h0203, 32'h3);
        mid();
        chk("bp_rrptr3", chnl_ready, 8);
        chk("bp_cnt1", rd_outstanding, 1);
        tick();
        clr_req();
        mem_ready = 1'b0;
        ret(32'h22);
        tick();
        mem_rdatvld = 1'b0;
        mid();
        chk("bp_cnt0", rd_outstanding, 0);
        tick();

        // read routing: ch1, ch3, ch0
        rd_one(1, 16'h0031, "rt_acc1");
        rd_one(3, 16'h0033, "rt_acc3");
        rd_one(0, 16'h0030, "rt_acc0");
        ret(32'hA);
        tick();
        ret(32'hB);
        tick();
        ret(32'hC);
        tick();
        mem_rdatvld = 1'b0;
        mid();
        chk("rt_cnt0", rd_outstanding, 0);
        tick();

        // FIFO full
        for (int k = 0; k < 4; k++) rd_one(k, AW'(16'h40 + k), "full_acc");
        set_req(0, 1'b1, 1'b0, 16'h0050, '0);
        set_req(1, 1'b0, 1'b1, 16'h0051, 32'h51);
        mem_ready = 1'b1;
        mid();
        chk("full_cnt_a", rd_outstanding, 4);
        chk("full_wr_gnt", chnl_ready, 2);
        chk("full_memwr", mem_wr, 1);
        tick();
        chnl_wr[1] = 1'b0;
        ret(32'hD0);
        mid();
        chk("full_pop_nogrant", chnl_ready, 0);
        chk("full_cnt_b", rd_outstanding, 4);
        tick();
        mem_rdatvld = 1'b0;
        mid();
        chk("full_cnt_c", rd_outstanding, 3);
        chk("full_rd_gnt", chnl_ready, 1);
        idq.push_back(0);
        tick();
        clr_req();
        mem_ready = 1'b0;
        mid();
        chk("full_cnt_d", rd_outstanding, 4);
        tick();
        for (int k = 1; k <= 4; k++) begin
            ret(DW'(32'hD0 + k));
            tick();
        end
        mem_rdatvld = 1'b0;
        mid();
        chk("full_drain", rd_outstanding, 0);
        tick();

        // spurious return
        ret(32'hEE);
        tick();
        mem_rdatvld = 1'b0;
        mid();
        chk("spur_perr", proterr, 1);
        tick();
        mid();
        chk("spur_perr_clr", proterr, 0);
        tick();

        // rd and wr together on ch1
        set_req(1, 1'b1, 1'b1, 16'h0061, 32'h61);
        mem_ready = 1'b1;
        mid();
        chk("both_memwr", mem_wr, 1);
        chk("both_memrd", mem_rd, 0);
        chk("both_ready", chnl_ready, 2);
        chk("both_wdat", mem_wdat, 32'h61);
        tick();
        clr_req();
        mem_ready = 1'b0;
        mid();
        chk("both_perr", proterr, 1);
        chk("both_cnt", rd_outstanding, 0);
        tick();

        // enable low
        enable = 1'b0;
        set_req(0, 1'b0, 1'b1, 16'h0070, 32'h70);
        set_req(2, 1'b1, 1'b0, 16'h0072, '0);
        mem_ready = 1'b1;
        mid();
        chk("en_memrd", mem_rd, 0);
        chk("en_memwr", mem_wr, 0);
        chk("en_ready", chnl_ready, 0);
        tick();
        enable = 1'b1;
        clr_req();
        mem_ready = 1'b0;

        // reset with two reads in flight
        rd_one(0, 16'h0080, "rst_acc0");
        rd_one(1, 16'h0081, "rst_acc1");
        mid();
        chk("rst_pre_cnt", rd_outstanding, 2);
        tick();
        reset = 1'b1;
        idq.delete();
        #1;
        chk("rst2_cnt", rd_outstanding, 0);
        chk("rst2_rdat", chnl_rdat, 0);
        chk("rst2_rdatvld", chnl_rdatvld, 0);
        chk("rst2_perr", proterr, 0);
        chk("rst2_memrd", mem_rd, 0);
        chk("rst2_memwr", mem_wr, 0);
        chk("rst2_ready", chnl_ready, 0);
        tick();
        reset = 1'b0;
        ret(32'h77);
        tick();
        mem_rdatvld = 1'b0;
        mid();
        chk("rst_spur_perr", proterr, 1);
        tick();
        repeat (2) tick();

        chk("sb_left", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
